// File: rtl/srio_prbs_lane_tester.sv
// Multi-lane PRBS-7/PRBS-31 generator and self-synchronous checker for SRIO lane bring-up.
// Each lane has a HUNT/LOCKED FSM, a saturating errored-word counter and a one-shot bit-0 error injection.
module srio_prbs_lane_tester #(
  parameter int          LANES    = 4,
  parameter int          DATA_W   = 16,
  parameter logic [30:0] SEED     = 31'h7FFFFFFF,
  parameter int          LOCK_CNT = 64,
  parameter int          LOSS_CNT = 4
) (
  input  logic                      log_clk,
  input  logic                      log_rst,
  input  logic                      mode,
  input  logic                      gen_en,
  input  logic                      inj_err,
  input  logic [LANES-1:0]          inj_lane,
  input  logic                      clr_cnt,
  output logic [LANES*DATA_W-1:0]   tx_data,
  output logic                      tx_valid,
  input  logic [LANES*DATA_W-1:0]   rx_data,
  input  logic [LANES-1:0]          rx_valid,
  output logic [LANES-1:0]          lock,
  output logic [LANES*16-1:0]       err_cnt
);

  localparam int HIST_W = 31;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  typedef enum logic {HUNT, LOCKED} lane_state_t;

  logic                     mode_q;
  logic                     mode_chg;
  logic [HIST_W-1:0]        gen_state;
  logic [HIST_W-1:0]        gen_next;
  logic [DATA_W-1:0]        gen_word;
  logic                     gen_fb;
  logic                     inj_pending;
  logic [LANES-1:0]         inj_mask;
  logic                     inj_eff;
  logic [LANES-1:0]         inj_mask_eff;
  logic [HIST_W-1:0]        hist      [LANES];
  logic [HIST_W-1:0]        hist_next [LANES];
  logic [LANES-1:0]         word_bad;
  logic [HIST_W+DATA_W-1:0] chk_cat;
  logic                     chk_exp;
  lane_state_t              lane_st   [LANES];
  logic [GOOD_W-1:0]        good_run  [LANES];
  logic [BAD_W-1:0]         bad_run   [LANES];
  logic [15:0]              cnt       [LANES];

  assign mode_chg     = mode != mode_q;
  assign inj_eff      = inj_pending | inj_err;
  assign inj_mask_eff = inj_pending ? inj_mask : inj_lane;

  // State bit 0 is the most recent sequence bit; DATA_W new bits are unrolled per word, first bit to the MSB.
  always_comb begin
    gen_next = gen_state;
    gen_word = '0;
    gen_fb   = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      gen_fb = mode ? (gen_next[30] ^ gen_next[27]) : (gen_next[6] ^ gen_next[5]);
      gen_word[DATA_W-1-j] = gen_fb;
      gen_next = {gen_next[HIST_W-2:0], gen_fb};
    end
  end

  // Received word appended below its history, so the taps of any bit may reach back into the same word.
  always_comb begin
    word_bad = '0;
    chk_cat  = '0;
    chk_exp  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      chk_cat = {hist[k], rx_data[k*DATA_W +: DATA_W]};
      for (int p = 0; p < DATA_W; p++) begin
        chk_exp = mode ? (chk_cat[p+31] ^ chk_cat[p+28]) : (chk_cat[p+7] ^ chk_cat[p+6]);
        if (chk_cat[p] != chk_exp) word_bad[k] = 1'b1;
      end
      hist_next[k] = chk_cat[HIST_W-1:0];
    end
  end

  // A mode change cycle reloads the seed and emits no word; a pending injection survives it.
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      mode_q      <= mode;
      gen_state   <= SEED;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      inj_pending <= 1'b0;
      inj_mask    <= '0;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        gen_state   <= SEED;
        tx_valid    <= 1'b0;
        inj_pending <= inj_eff;
        inj_mask    <= inj_mask_eff;
      end else if (gen_en) begin
        gen_state   <= gen_next;
        tx_valid    <= 1'b1;
        inj_pending <= 1'b0;
        for (int k = 0; k < LANES; k++)
          tx_data[k*DATA_W +: DATA_W] <= gen_word ^ DATA_W'(inj_eff & inj_mask_eff[k]);
      end else begin
        tx_valid    <= 1'b0;
        inj_pending <= inj_eff;
        inj_mask    <= inj_mask_eff;
      end
    end
  end

  always_ff @(posedge log_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (log_rst || mode_chg) begin
        hist[k]     <= '0;
        lane_st[k]  <= HUNT;
        lock[k]     <= 1'b0;
        good_run[k] <= '0;
        bad_run[k]  <= '0;
      end else if (rx_valid[k]) begin
        hist[k] <= hist_next[k];
        case (lane_st[k])
          HUNT: begin
            if (word_bad[k]) begin
              good_run[k] <= '0;
            end else if (good_run[k] == GOOD_W'(LOCK_CNT - 1)) begin
              lane_st[k]  <= LOCKED;
              lock[k]     <= 1'b1;
              good_run[k] <= '0;
              bad_run[k]  <= '0;
            end else begin
              good_run[k] <= good_run[k] + GOOD_W'(1);
            end
          end
          LOCKED: begin
            if (!word_bad[k]) begin
              bad_run[k] <= '0;
            end else if (bad_run[k] == BAD_W'(LOSS_CNT - 1)) begin
              lane_st[k]  <= HUNT;
              lock[k]     <= 1'b0;
              good_run[k] <= '0;
              bad_run[k]  <= '0;
            end else begin
              bad_run[k] <= bad_run[k] + BAD_W'(1);
            end
          end
          default: lane_st[k] <= HUNT;
        endcase
      end
    end
  end

  // Counting uses the pre-update FSM state, so the word that drops lock is still counted.
  always_ff @(posedge log_clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (log_rst || clr_cnt)
        cnt[k] <= '0;
      else if (rx_valid[k] && !mode_chg && word_bad[k] && lane_st[k] == LOCKED && cnt[k] != 16'hFFFF)
        cnt[k] <= cnt[k] + 16'd1;
    end
  end

  always_comb begin
    err_cnt = '0;
    for (int k = 0; k < LANES; k++) err_cnt[k*16 +: 16] = cnt[k];
  end

endmodule

// File: tb/tb_srio_prbs_lane_tester.sv
// Directed-plus-random bench for srio_prbs_lane_tester with a bit-sequence reference model.
// Outputs are compared every cycle 1 time unit after the rising edge.
module tb_srio_prbs_lane_tester;

  localparam int          LANES  = 4;
  localparam int          DATA_W = 16;
  localparam logic [30:0] SEED   = 31'h7FFFFFFF;

  logic                    log_clk = 1'b0;
  logic                    log_rst;
  logic                    mode;
  logic                    gen_en;
  logic                    inj_err;
  logic [LANES-1:0]        inj_lane;
  logic                    clr_cnt;
  logic [LANES*DATA_W-1:0] tx_data;
  logic                    tx_valid;
  logic [LANES*DATA_W-1:0] rx_data;
  logic [LANES-1:0]        rx_valid;
  logic [LANES-1:0]        lock;
  logic [LANES*16-1:0]     err_cnt;

  logic [LANES-1:0]        inv_lane;
  int                      n_compared   = 0;
  int                      n_mismatched = 0;

  // Reference model: explicit bit sequences, oldest bit first.
  bit                      gen_seq [$];
  bit                      rx_seq  [LANES][$];
  bit                      m_locked [LANES];
  int                      m_good   [LANES];
  int                      m_bad    [LANES];
  int                      m_err    [LANES];
  bit                      m_pending;
  logic [LANES-1:0]        m_mask;
  bit                      m_mode_prev;
  logic [LANES*DATA_W-1:0] m_tx;
  bit                      m_tx_valid;

  srio_prbs_lane_tester #(
    .LANES(LANES), .DATA_W(DATA_W), .SEED(SEED), .LOCK_CNT(64), .LOSS_CNT(4)
  ) dut (
    .log_clk(log_clk), .log_rst(log_rst), .mode(mode), .gen_en(gen_en),
    .inj_err(inj_err), .inj_lane(inj_lane), .clr_cnt(clr_cnt),
    .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .lock(lock), .err_cnt(err_cnt)
  );

  always #5 log_clk = ~log_clk;

  function automatic void model_seed_gen();
    gen_seq.delete();
    for (int i = 30; i >= 0; i--) gen_seq.push_back(SEED[i]);
  endfunction

  function automatic void model_clear_rx();
    for (int k = 0; k < LANES; k++) begin
      rx_seq[k].delete();
      for (int i = 0; i < 31; i++) rx_seq[k].push_back(1'b0);
      m_locked[k] = 1'b0;
      m_good[k]   = 0;
      m_bad[k]    = 0;
    end
  endfunction

  function automatic logic [DATA_W-1:0] model_next_word(bit m);
    logic [DATA_W-1:0] w = '0;
    for (int j = 0; j < DATA_W; j++) begin
      int n = gen_seq.size();
      bit b = m ? (gen_seq[n-31] ^ gen_seq[n-28]) : (gen_seq[n-7] ^ gen_seq[n-6]);
      w[DATA_W-1-j] = b;
      gen_seq.push_back(b);
      if (gen_seq.size() > 64) gen_seq.delete(0);
    end
    return w;
  endfunction

  function automatic bit model_check(int k, logic [DATA_W-1:0] w, bit m);
    bit bad = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      int n = rx_seq[k].size();
      bit e = m ? (rx_seq[k][n-31] ^ rx_seq[k][n-28]) : (rx_seq[k][n-7] ^ rx_seq[k][n-6]);
      if (w[DATA_W-1-j] != e) bad = 1'b1;
      rx_seq[k].push_back(w[DATA_W-1-j]);
      if (rx_seq[k].size() > 64) rx_seq[k].delete(0);
    end
    return bad;
  endfunction

  // Advances the model by one clock using the inputs that were stable at the edge.
  function automatic void model_step();
    bit               chg;
    bit               valid_k [LANES];
    bit               bad_k   [LANES];
    bit               eff_pending;
    logic [LANES-1:0] eff_mask;
    logic [DATA_W-1:0] w;
    if (log_rst) begin
      m_tx = '0; m_tx_valid = 1'b0; m_pending = 1'b0; m_mask = '0; m_mode_prev = mode;
      model_seed_gen();
      model_clear_rx();
      for (int k = 0; k < LANES; k++) m_err[k] = 0;
      return;
    end
    chg = (mode != m_mode_prev);
    m_mode_prev = mode;
    for (int k = 0; k < LANES; k++) begin
      valid_k[k] = rx_valid[k] && !chg;
      bad_k[k]   = valid_k[k] ? model_check(k, rx_data[k*DATA_W +: DATA_W], mode) : 1'b0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (clr_cnt) m_err[k] = 0;
      else if (valid_k[k] && bad_k[k] && m_locked[k] && m_err[k] < 65535) m_err[k]++;
    end
    for (int k = 0; k < LANES; k++) begin
      if (!valid_k[k]) continue;
      if (!m_locked[k]) begin
        m_good[k] = bad_k[k] ? 0 : m_good[k] + 1;
        if (m_good[k] == 64) begin m_locked[k] = 1'b1; m_good[k] = 0; m_bad[k] = 0; end
      end else begin
        m_bad[k] = bad_k[k] ? m_bad[k] + 1 : 0;
        if (m_bad[k] == 4) begin m_locked[k] = 1'b0; m_good[k] = 0; m_bad[k] = 0; end
      end
    end
    eff_pending = m_pending || inj_err;
    eff_mask    = m_pending ? m_mask : inj_lane;
    if (chg) begin
      model_seed_gen();
      model_clear_rx();
      m_tx_valid = 1'b0;
      m_pending = eff_pending; m_mask = eff_mask;
    end else if (gen_en) begin
      w = model_next_word(mode);
      for (int k = 0; k < LANES; k++) begin
        m_tx[k*DATA_W +: DATA_W] = w;
        if (eff_pending && eff_mask[k]) m_tx[k*DATA_W] = ~w[0];
      end
      m_tx_valid = 1'b1;
      m_pending  = 1'b0;
    end else begin
      m_tx_valid = 1'b0;
      m_pending = eff_pending; m_mask = eff_mask;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_compared++;
    assert (observed === expected)
      else begin
        n_mismatched++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One clock: loop tx back to rx (optionally inverted per lane), then compare everything against the model.
  task automatic applyStimulus();
    logic [LANES*16-1:0] exp_err;
    logic [LANES-1:0]    exp_lock;
    for (int k = 0; k < LANES; k++)
      rx_data[k*DATA_W +: DATA_W] = inv_lane[k] ? ~tx_data[k*DATA_W +: DATA_W] : tx_data[k*DATA_W +: DATA_W];
    rx_valid = {LANES{tx_valid}};
    @(posedge log_clk);
    model_step();
    #1;
    for (int k = 0; k < LANES; k++) begin
      exp_err[k*16 +: 16] = 16'(m_err[k]);
      exp_lock[k]         = m_locked[k];
    end
    checkOutput("tx_data",  128'(tx_data),  128'(m_tx));
    checkOutput("tx_valid", 128'(tx_valid), 128'(m_tx_valid));
    checkOutput("lock",     128'(lock),     128'(exp_lock));
    checkOutput("err_cnt",  128'(err_cnt),  128'(exp_err));
  endtask

  task automatic runCycles(input int n, input int gen_pct);
    for (int i = 0; i < n; i++) begin
      gen_en = ($urandom_range(99) < gen_pct);
      applyStimulus();
    end
  endtask

  initial begin
    log_rst = 1'b1; mode = 1'b0; gen_en = 1'b0; inj_err = 1'b0; inj_lane = '0;
    clr_cnt = 1'b0; inv_lane = '0; rx_data = '0; rx_valid = '0;
    #1;
    repeat (3) applyStimulus();
    checkOutput("reset_tx_data", 128'(tx_data), 128'(0));
    checkOutput("reset_lock",    128'(lock),    128'(0));
    log_rst = 1'b0;

    gen_en = 1'b1;
    applyStimulus();
    checkOutput("first_word", 128'(tx_data), 128'({4{16'h020C}}));

    runCycles(160, 75);
    checkOutput("lock_prbs7", 128'(lock),    128'(4'hF));
    checkOutput("lock_err0",  128'(err_cnt), 128'(0));

    gen_en = 1'b1; inj_err = 1'b1; inj_lane = 4'b0010;
    applyStimulus();
    inj_err = 1'b0; inj_lane = '0;
    runCycles(10, 100);
    checkOutput("inj_err_cnt", 128'(err_cnt), 128'({16'd0, 16'd0, 16'd2, 16'd0}));
    checkOutput("inj_lock",    128'(lock),    128'(4'hF));

    gen_en = 1'b1; inv_lane = 4'b0100;
    repeat (3) applyStimulus();
    checkOutput("loss_hold", 128'(lock), 128'(4'hF));
    applyStimulus();
    inv_lane = '0;
    checkOutput("loss_lock", 128'(lock),    128'(4'b1011));
    checkOutput("loss_cnt",  128'(err_cnt), 128'({16'd0, 16'd4, 16'd2, 16'd0}));
    runCycles(110, 100);
    checkOutput("relock", 128'(lock), 128'(4'hF));

    gen_en = 1'b1; inv_lane = 4'b0001;
    repeat (2) applyStimulus();
    inv_lane = '0;
    applyStimulus();
    checkOutput("pre_clr_cnt", 128'(err_cnt), 128'({16'd0, 16'd4, 16'd2, 16'd3}));
    inv_lane = 4'b0001; clr_cnt = 1'b1;
    applyStimulus();
    inv_lane = '0; clr_cnt = 1'b0;
    checkOutput("clr_priority", 128'(err_cnt), 128'(0));
    runCycles(4, 100);

    mode = 1'b1; gen_en = 1'b1;
    applyStimulus();
    checkOutput("mode_lock_drop", 128'(lock),     128'(0));
    checkOutput("mode_tx_valid",  128'(tx_valid), 128'(0));
    runCycles(150, 100);
    checkOutput("lock_prbs31", 128'(lock), 128'(4'hF));

    for (int i = 0; i < 300; i++) begin
      gen_en   = ($urandom_range(99) < 85);
      inj_err  = ($urandom_range(19) == 0);
      inj_lane = LANES'($urandom_range(15));
      clr_cnt  = ($urandom_range(49) == 0);
      inv_lane = ($urandom_range(29) == 0) ? LANES'(1 << $urandom_range(LANES-1)) : '0;
      if ($urandom_range(149) == 0) mode = ~mode;
      applyStimulus();
    end
    inj_err = 1'b0; inj_lane = '0; clr_cnt = 1'b0; inv_lane = '0;

    mode = 1'b0; gen_en = 1'b0;
    applyStimulus();
    inj_err = 1'b1; inj_lane = 4'hF;
    applyStimulus();
    inj_err = 1'b0; inj_lane = '0; log_rst = 1'b1;
    applyStimulus();
    log_rst = 1'b0;
    checkOutput("midrst_cnt",  128'(err_cnt), 128'(0));
    checkOutput("midrst_lock", 128'(lock),    128'(0));
    gen_en = 1'b1;
    applyStimulus();
    checkOutput("midrst_no_inj", 128'(tx_data), 128'({4{16'h020C}}));
    runCycles(80, 100);
    checkOutput("midrst_relock", 128'(lock),    128'(4'hF));
    checkOutput("midrst_err0",   128'(err_cnt), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
